// File: rtl/corr_sweep_ctrl_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// corr_sweep_ctrl_pkg
// Shared definitions for the correlation sweep controller and its best-match
// tracker: sweep state encoding, coordinate/score/watchdog widths and the
// overflow-safe coordinate advance test.
// ---------------------------------------------------------------------------
package corr_sweep_ctrl_pkg;

    localparam int COORD_W = 13;
    localparam int SCORE_W = 32;
    localparam int WDOG_W  = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } sweep_state_e;

    // True when cur+step still lies inside [0, last]. The sum is formed one
    // bit wider than a coordinate so a last position near 8191 cannot wrap
    // back to a small value and restart the axis.
    function automatic logic step_fits(input logic [COORD_W-1:0] cur,
                                       input logic [COORD_W-1:0] step,
                                       input logic [COORD_W-1:0] last);
        logic [COORD_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum <= {1'b0, last});
    endfunction

endpackage

// File: rtl/corr_best_tracker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// corr_best_tracker
// Holds the best score seen so far in a sweep together with the start
// coordinates that produced it.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   clear_i          : forget the current best (start of a new sweep)
//   load_en_i        : a scored candidate is presented this cycle
//   score_i, x_i, y_i: candidate score and its start coordinates
//   valid_o          : at least one candidate has been accepted
//   score_o, x_o, y_o: best score and its coordinates
// ---------------------------------------------------------------------------
module corr_best_tracker
    import corr_sweep_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               load_en_i,
    input  logic [SCORE_W-1:0] score_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               valid_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o
);

    logic               valid_q;
    logic [SCORE_W-1:0] score_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               take_d;

    // Strictly-greater keeps the earlier raster position on a tie; the very
    // first candidate of a sweep is always taken, even a score of zero.
    assign take_d = load_en_i && (!valid_q || (score_i > score_q));

    // Best-match register: clear wins over load so a new sweep always starts
    // from an empty best.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            score_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            score_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (take_d) begin
            valid_q <= 1'b1;
            score_q <= score_i;
            x_q     <= x_i;
            y_q     <= y_i;
        end
    end

    assign valid_o = valid_q;
    assign score_o = score_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/corr_sweep_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// corr_sweep_ctrl
// Steps the correlation score engine over every candidate start position of
// the search window (raster order, X fastest) and keeps the best match.
//   iCLK, iRST        : clock, asynchronous active-high reset
//   iStart            : one-cycle sweep request, ignored while busy
//   oControllerReady  : run enable to the score engine
//   oXstart, oYstart  : candidate start position for the engine
//   iFinished, iScore : engine pass-complete flag and its score
//   oBusy, oDone      : sweep in progress / one-cycle end-of-sweep pulse
//   oError            : a pass hit the watchdog limit
//   oBestValid/X/Y/Score : best match of the latest sweep
// ---------------------------------------------------------------------------
module corr_sweep_ctrl
    import corr_sweep_ctrl_pkg::*;
#(
    parameter logic [COORD_W-1:0] X_LAST  = 13'd160,
    parameter logic [COORD_W-1:0] Y_LAST  = 13'd120,
    parameter logic [COORD_W-1:0] STEP    = 13'd1,
    parameter logic [WDOG_W-1:0]  TIMEOUT = 24'd1_000_000
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    output logic               oControllerReady,
    output logic [COORD_W-1:0] oXstart,
    output logic [COORD_W-1:0] oYstart,
    input  logic               iFinished,
    input  logic [SCORE_W-1:0] iScore,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output logic               oBestValid,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [SCORE_W-1:0] oBestScore
);

    sweep_state_e       state_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               flush_pending_q;
    logic               discard_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [WDOG_W-1:0]  wdog_q;

    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;
    logic [WDOG_W-1:0]  wdog_d;
    logic               x_fits;
    logic               y_fits;
    logic               best_clear;
    logic               best_load;

    // Candidate next coordinates and the bounds test for each axis.
    assign x_d    = x_q + STEP;
    assign y_d    = y_q + STEP;
    assign x_fits = step_fits(x_q, STEP, X_LAST);
    assign y_fits = step_fits(y_q, STEP, Y_LAST);
    assign wdog_d = wdog_q + 24'd1;

    // The score of the flush pass is never offered to the tracker.
    assign best_clear = (state_q == ST_IDLE) && iStart;
    assign best_load  = (state_q == ST_CAPTURE) && !discard_q;

    // Sweep sequencer. Coordinates are only updated on edges that leave a
    // ready-low cycle (IDLE or CAPTURE), so the engine always sees a stable
    // start position for the whole time it is enabled. flush_pending survives
    // across sweeps and is only re-armed by reset, because only a reset can
    // interrupt the engine mid-pass and leave stale partial state in it.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q         <= ST_IDLE;
            ready_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            flush_pending_q <= 1'b1;
            discard_q       <= 1'b0;
            x_q             <= '0;
            y_q             <= '0;
            wdog_q          <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        error_q <= 1'b0;
                        x_q     <= '0;
                        y_q     <= '0;
                        wdog_q  <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                        if (flush_pending_q) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (iFinished) begin
                        flush_pending_q <= 1'b0;
                        discard_q       <= 1'b1;
                        ready_q         <= 1'b0;
                        state_q         <= ST_CAPTURE;
                    end
                end
                ST_RUN: begin
                    // A finishing pass wins over a watchdog expiring on the
                    // same cycle.
                    if (iFinished) begin
                        discard_q <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= ST_CAPTURE;
                    end else if (wdog_d == TIMEOUT) begin
                        error_q <= 1'b1;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                ST_CAPTURE: begin
                    // After the discarded flush pass the same position (0,0)
                    // is run again for real, so no advance there.
                    if (discard_q) begin
                        wdog_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (x_fits) begin
                        x_q     <= x_d;
                        wdog_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_RUN;
                    end else if (y_fits) begin
                        x_q     <= '0;
                        y_q     <= y_d;
                        wdog_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    corr_best_tracker u_best (
        .clk_i     (iCLK),
        .rst_i     (iRST),
        .clear_i   (best_clear),
        .load_en_i (best_load),
        .score_i   (iScore),
        .x_i       (x_q),
        .y_i       (y_q),
        .valid_o   (oBestValid),
        .score_o   (oBestScore),
        .x_o       (oBestX),
        .y_o       (oBestY)
    );

    assign oControllerReady = ready_q;
    assign oXstart          = x_q;
    assign oYstart          = y_q;
    assign oBusy            = busy_q;
    assign oDone            = done_q;
    assign oError           = error_q;

endmodule

// File: tb/tb_corr_sweep_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_corr_sweep_ctrl
// Two controllers share clock and reset: instance A sweeps a 3x2 window with
// unit step and a 100-cycle watchdog, instance B sweeps X 0..10 / Y 0..4 with
// step 4. Each has a behavioural engine that finishes after 20 ready cycles
// and returns a score looked up in a randomly filled table. For each sweep
// the expected per-cycle output trace is built from the window geometry and
// the best-match rules, then compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_corr_sweep_ctrl;

    localparam int N  = 20;
    localparam int TO = 100;

    typedef struct packed {
        logic        rdy;
        logic [12:0] x;
        logic [12:0] y;
        logic        busy;
        logic        done;
        logic        err;
        logic        bv;
        logic [12:0] bx;
        logic [12:0] by;
        logic [31:0] bs;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  startSig = 2'b00;
    logic [1:0]  rdy, fin, busy, done, err, bv;
    logic [12:0] xs [2];
    logic [12:0] ys [2];
    logic [12:0] bx [2];
    logic [12:0] by [2];
    logic [31:0] bs [2];
    logic [31:0] scr [2];

    int          engCnt [2] = '{0, 0};
    bit          hang = 1'b0;
    logic [31:0] tab [0:15][0:15];
    bit          flushPend [2];

    obs_t        expQ0 [$];
    obs_t        expQ1 [$];

    int          checks = 0;
    int          failures = 0;
    int          passCnt [2] = '{0, 0};
    int          rdyCnt [2] = '{0, 0};
    logic [15:0] xMask [2] = '{16'h0, 16'h0};
    logic [15:0] yMask [2] = '{16'h0, 16'h0};
    int          xMax [2] = '{0, 0};
    logic        prevRdy [2] = '{1'b0, 1'b0};
    logic        prevBusy [2] = '{1'b0, 1'b0};
    logic [12:0] prevX [2] = '{13'd0, 13'd0};
    logic [12:0] prevY [2] = '{13'd0, 13'd0};
    int          lowLen [2] = '{0, 0};
    logic        prevRst = 1'b0;

    always #10 clk = ~clk;

    corr_sweep_ctrl #(.X_LAST(13'd2), .Y_LAST(13'd1), .STEP(13'd1), .TIMEOUT(24'd100)) dutA (
        .iCLK(clk), .iRST(rst), .iStart(startSig[0]), .oControllerReady(rdy[0]),
        .oXstart(xs[0]), .oYstart(ys[0]), .iFinished(fin[0]), .iScore(scr[0]),
        .oBusy(busy[0]), .oDone(done[0]), .oError(err[0]), .oBestValid(bv[0]),
        .oBestX(bx[0]), .oBestY(by[0]), .oBestScore(bs[0]));

    corr_sweep_ctrl #(.X_LAST(13'd10), .Y_LAST(13'd4), .STEP(13'd4), .TIMEOUT(24'd100)) dutB (
        .iCLK(clk), .iRST(rst), .iStart(startSig[1]), .oControllerReady(rdy[1]),
        .oXstart(xs[1]), .oYstart(ys[1]), .iFinished(fin[1]), .iScore(scr[1]),
        .oBusy(busy[1]), .oDone(done[1]), .oError(err[1]), .oBestValid(bv[1]),
        .oBestX(bx[1]), .oBestY(by[1]), .oBestScore(bs[1]));

    // Engine model: keeps its partial count across controller resets, raises
    // finished on the 20th enabled cycle and latches the score on that edge.
    function automatic logic [31:0] lookup(input logic [12:0] x, input logic [12:0] y);
        if (x < 13'd16 && y < 13'd16) return tab[x[3:0]][y[3:0]];
        return 32'd0;
    endfunction

    assign fin[0] = rdy[0] && !hang && (engCnt[0] == N - 1);
    assign fin[1] = rdy[1] && !hang && (engCnt[1] == N - 1);

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rdy[i]) begin
                if (fin[i]) begin
                    engCnt[i] <= 0;
                    scr[i]    <= lookup(xs[i], ys[i]);
                end else begin
                    engCnt[i] <= engCnt[i] + 1;
                end
            end
        end
    end

    function automatic obs_t sample(input int g);
        obs_t o;
        o.rdy  = rdy[g];
        o.x    = xs[g];
        o.y    = ys[g];
        o.busy = busy[g];
        o.done = done[g];
        o.err  = err[g];
        o.bv   = bv[g];
        o.bx   = bx[g];
        o.by   = by[g];
        o.bs   = bs[g];
        return o;
    endfunction

    task automatic checkOutput(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got rdy=%0d x=%0d y=%0d busy=%0d done=%0d err=%0d bv=%0d bx=%0d by=%0d bs=%0d want rdy=%0d x=%0d y=%0d busy=%0d done=%0d err=%0d bv=%0d bx=%0d by=%0d bs=%0d",
                     name, got.rdy, got.x, got.y, got.busy, got.done, got.err, got.bv, got.bx, got.by, got.bs,
                     want.rdy, want.x, want.y, want.busy, want.done, want.err, want.bv, want.bx, want.by, want.bs);
        end
    endtask

    task automatic checkVal(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic pushExp(input int g, input obs_t e);
        if (g == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    function automatic int expSize(input int g);
        return (g == 0) ? expQ0.size() : expQ1.size();
    endfunction

    // Expected trace of one sweep, starting with the first cycle after the
    // iStart edge and ending with the first idle cycle after oDone.
    task automatic buildTrace(input int g, input int xl, input int yl, input int st, input bit hangMode);
        obs_t        e;
        logic [31:0] s;
        e = '0;
        e.rdy  = 1'b1;
        e.busy = 1'b1;
        if (hangMode) begin
            repeat (TO) pushExp(g, e);
            e.rdy = 1'b0; e.done = 1'b1; e.err = 1'b1;
            pushExp(g, e);
            e.done = 1'b0; e.busy = 1'b0;
            pushExp(g, e);
            return;
        end
        if (flushPend[g]) begin
            repeat (N - engCnt[g]) pushExp(g, e);
            e.rdy = 1'b0;
            pushExp(g, e);
            flushPend[g] = 1'b0;
        end
        for (int y = 0; y <= yl; y += st) begin
            for (int x = 0; x <= xl; x += st) begin
                e.x   = 13'(x);
                e.y   = 13'(y);
                e.rdy = 1'b1;
                repeat (N) pushExp(g, e);
                e.rdy = 1'b0;
                pushExp(g, e);
                s = tab[x][y];
                if (!e.bv || s > e.bs) begin
                    e.bv = 1'b1; e.bs = s; e.bx = 13'(x); e.by = 13'(y);
                end
            end
        end
        e.done = 1'b1;
        pushExp(g, e);
        e.done = 1'b0; e.busy = 1'b0;
        pushExp(g, e);
    endtask

    // Compare process: trace check every cycle an expectation is queued, plus
    // the pass-gap and coordinate-stability rules and pass bookkeeping.
    always @(posedge clk) begin
        obs_t o;
        obs_t w;
        #1;
        for (int g = 0; g < 2; g++) begin
            o = sample(g);
            if (g == 0 && expQ0.size() > 0) begin
                w = expQ0.pop_front();
                checkOutput("traceA", o, w);
            end
            if (g == 1 && expQ1.size() > 0) begin
                w = expQ1.pop_front();
                checkOutput("traceB", o, w);
            end
            if (!rst && !prevRst) begin
                if (o.x != prevX[g] || o.y != prevY[g])
                    checkVal("coordChangeWhileReady", longint'(prevRdy[g]), 0);
                if (o.rdy && !prevRdy[g]) begin
                    passCnt[g]++;
                    if (prevBusy[g]) checkVal("passGap", lowLen[g], 1);
                    xMask[g][(o.x < 13'd15) ? o.x[3:0] : 4'd15] = 1'b1;
                    yMask[g][(o.y < 13'd15) ? o.y[3:0] : 4'd15] = 1'b1;
                end
                if (int'(o.x) > xMax[g]) xMax[g] = int'(o.x);
            end
            if (o.rdy) rdyCnt[g]++;
            lowLen[g]   = o.rdy ? 0 : lowLen[g] + 1;
            prevRdy[g]  = o.rdy;
            prevBusy[g] = o.busy;
            prevX[g]    = o.x;
            prevY[g]    = o.y;
        end
        prevRst = rst;
    end

    task automatic fillTable(input bit fullRange, input int maxVal);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                tab[x][y] = fullRange ? $urandom() : $urandom_range(0, maxVal);
    endtask

    // Runs one sweep on instance g. abortAt>0 returns that many cycles after
    // the start pulse instead of waiting for the sweep to complete.
    task automatic applyStimulus(input int g, input int xl, input int yl, input int st,
                                 input bit hangMode, input bit pokeStart, input int abortAt);
        int cyc;
        @(negedge clk);
        buildTrace(g, xl, yl, st, hangMode);
        startSig[g] = 1'b1;
        @(negedge clk);
        startSig[g] = 1'b0;
        cyc = 1;
        if (abortAt > 0) begin
            repeat (abortAt - 1) @(negedge clk);
            return;
        end
        while (expSize(g) > 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            startSig[g] = pokeStart && (cyc == 30);
        end
        startSig[g] = 1'b0;
        checkVal("sweepCompletes", expSize(g), 0);
    endtask

    initial begin
        int base;
        int rbase;
        flushPend = '{1'b1, 1'b1};
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetA", sample(0), '0);
        checkOutput("resetB", sample(1), '0);
        rst = 1'b0;

        $display("[TB] test 1: flush then 3x2 sweep, peak at (1,1)");
        fillTable(1'b0, 4000);
        tab[1][1] = 32'd5000;
        base = passCnt[0];
        applyStimulus(0, 2, 1, 1, 1'b0, 1'b0, 0);
        checkVal("t1Passes", passCnt[0] - base, 7);
        checkVal("t1BestX", bx[0], 1);
        checkVal("t1BestY", by[0], 1);
        checkVal("t1BestScore", bs[0], 5000);
        checkVal("t1BestValid", bv[0], 1);

        $display("[TB] test 2: tie between (0,0) and (2,0)");
        fillTable(1'b0, 899);
        tab[0][0] = 32'd900;
        tab[2][0] = 32'd900;
        base = passCnt[0];
        applyStimulus(0, 2, 1, 1, 1'b0, 1'b0, 0);
        checkVal("t2Passes", passCnt[0] - base, 6);
        checkVal("t2BestX", bx[0], 0);
        checkVal("t2BestY", by[0], 0);
        checkVal("t2BestScore", bs[0], 900);

        $display("[TB] test 7: full-range random scores, start poked mid-sweep");
        for (int r = 0; r < 3; r++) begin
            fillTable(1'b1, 0);
            base = passCnt[0];
            applyStimulus(0, 2, 1, 1, 1'b0, 1'b1, 0);
            checkVal("t7Passes", passCnt[0] - base, 6);
        end

        $display("[TB] test 5: reset during third pass");
        fillTable(1'b0, 999);
        tab[2][1] = 32'd3000;
        applyStimulus(0, 2, 1, 1, 1'b0, 1'b0, 50);
        expQ0.delete();
        rst = 1'b1;
        #2;
        checkOutput("t5ResetA", sample(0), '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flushPend = '{1'b1, 1'b1};
        base = passCnt[0];
        applyStimulus(0, 2, 1, 1, 1'b0, 1'b0, 0);
        checkVal("t5Passes", passCnt[0] - base, 7);
        checkVal("t5BestX", bx[0], 2);
        checkVal("t5BestY", by[0], 1);
        checkVal("t5BestScore", bs[0], 3000);

        $display("[TB] test 3: step 4 over X 0..10, Y 0..4");
        fillTable(1'b0, 5000);
        tab[8][4] = 32'd7777;
        base = passCnt[1];
        applyStimulus(1, 10, 4, 4, 1'b0, 1'b0, 0);
        checkVal("t3Passes", passCnt[1] - base, 7);
        checkVal("t3XVisited", xMask[1], 16'h0111);
        checkVal("t3YVisited", yMask[1], 16'h0011);
        checkVal("t3XMax", xMax[1], 8);
        checkVal("t3BestX", bx[1], 8);
        checkVal("t3BestY", by[1], 4);
        checkVal("t3BestScore", bs[1], 7777);

        $display("[TB] test 4: engine never finishes, watchdog abort");
        hang  = 1'b1;
        base  = passCnt[0];
        rbase = rdyCnt[0];
        applyStimulus(0, 2, 1, 1, 1'b1, 1'b0, 0);
        checkVal("t4ReadyCycles", rdyCnt[0] - rbase, 100);
        checkVal("t4Passes", passCnt[0] - base, 1);
        checkVal("t4Error", err[0], 1);
        checkVal("t4BestValid", bv[0], 0);
        hang = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
